// File: rtl/bme280_sequencer.sv
// BME280 sequencer: configures the sensor once, then polls status, reads the eight
// raw measurement bytes and publishes T/P/H words, paced by fixed transaction budgets.
module bme280_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR      = 7'h76,
    parameter int unsigned XFER_CYCLES     = 64,
    parameter int unsigned INTERVAL_CYCLES = 100000,
    parameter int unsigned MAX_POLLS       = 16,
    parameter logic [7:0]  CTRL_HUM_VAL    = 8'h01,
    parameter logic [7:0]  CTRL_MEAS_VAL   = 8'h27,
    parameter logic [7:0]  CONFIG_VAL      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        sample_valid,
    output logic [19:0] temp_raw,
    output logic [19:0] press_raw,
    output logic [15:0] hum_raw,
    output logic        error,
    output logic        i2c_en,
    output logic [6:0]  i2c_slave_address,
    output logic        i2c_read_write,
    output logic [7:0]  i2c_register_address,
    output logic [7:0]  i2c_data_out,
    input  logic [7:0]  i2c_data_in
);

    localparam int unsigned XFER_W = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam int unsigned INT_W  = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;
    localparam int unsigned POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PUBLISH,
        ST_INTERVAL,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        PH_CFG,
        PH_POLL,
        PH_READ
    } phase_t;

    state_t             state;
    phase_t             phase;
    logic [2:0]         idx;
    logic [XFER_W-1:0]  wait_cnt;
    logic [INT_W-1:0]   int_cnt;
    logic [POLL_W-1:0]  poll_cnt;
    logic [7:0]         rx_buf [8];

    assign i2c_slave_address = SLAVE_ADDR;

    // {read_write, register_address, data_out} for the transaction selected by phase/index
    function automatic logic [16:0] xfer_fields(input phase_t ph, input logic [2:0] i);
        logic [16:0] f;
        f = {1'b1, 8'hF3, 8'h00};
        case (ph)
            PH_CFG: begin
                case (i)
                    3'd0:    f = {1'b0, 8'hF2, CTRL_HUM_VAL};
                    3'd1:    f = {1'b0, 8'hF4, CTRL_MEAS_VAL};
                    default: f = {1'b0, 8'hF5, CONFIG_VAL};
                endcase
            end
            PH_POLL: f = {1'b1, 8'hF3, 8'h00};
            default: f = {1'b1, 8'hF7 + 8'(i), 8'h00};
        endcase
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                <= ST_IDLE;
            phase                <= PH_CFG;
            idx                  <= 3'd0;
            wait_cnt             <= '0;
            int_cnt              <= '0;
            poll_cnt             <= '0;
            busy                 <= 1'b0;
            sample_valid         <= 1'b0;
            temp_raw             <= 20'd0;
            press_raw            <= 20'd0;
            hum_raw              <= 16'd0;
            error                <= 1'b0;
            i2c_en               <= 1'b0;
            i2c_read_write       <= 1'b0;
            i2c_register_address <= 8'd0;
            i2c_data_out         <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                rx_buf[i] <= 8'd0;
            end
        end else begin
            i2c_en       <= 1'b0;
            sample_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        phase    <= PH_CFG;
                        idx      <= 3'd0;
                        poll_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                        i2c_en   <= 1'b1;
                        {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_CFG, 3'd0);
                    end
                end

                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_cnt != XFER_W'(XFER_CYCLES - 2)) begin
                        wait_cnt <= wait_cnt + XFER_W'(1);
                    end else if (phase == PH_READ) begin
                        // Byte lands in the buffer even when stopping; it is simply never published
                        rx_buf[idx] <= i2c_data_in;
                        if (!start) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (idx == 3'd7) begin
                            state <= ST_PUBLISH;
                        end else begin
                            idx    <= idx + 3'd1;
                            state  <= ST_ISSUE;
                            i2c_en <= 1'b1;
                            {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_READ, idx + 3'd1);
                        end
                    end else if (!start) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (phase == PH_CFG) begin
                        state  <= ST_ISSUE;
                        i2c_en <= 1'b1;
                        if (idx == 3'd2) begin
                            phase    <= PH_POLL;
                            poll_cnt <= '0;
                            {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_POLL, 3'd0);
                        end else begin
                            idx <= idx + 3'd1;
                            {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_CFG, idx + 3'd1);
                        end
                    end else begin
                        // Status poll: bit3 is the sensor's "measuring" flag
                        if (!i2c_data_in[3]) begin
                            phase  <= PH_READ;
                            idx    <= 3'd0;
                            state  <= ST_ISSUE;
                            i2c_en <= 1'b1;
                            {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_READ, 3'd0);
                        end else if (32'(poll_cnt) + 32'd1 < MAX_POLLS) begin
                            poll_cnt <= poll_cnt + POLL_W'(1);
                            state    <= ST_ISSUE;
                            i2c_en   <= 1'b1;
                            {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_POLL, 3'd0);
                        end else begin
                            error <= 1'b1;
                            state <= ST_HALT;
                        end
                    end
                end

                ST_PUBLISH: begin
                    sample_valid <= 1'b1;
                    press_raw    <= {rx_buf[0], rx_buf[1], rx_buf[2][7:4]};
                    temp_raw     <= {rx_buf[3], rx_buf[4], rx_buf[5][7:4]};
                    hum_raw      <= {rx_buf[6], rx_buf[7]};
                    int_cnt      <= '0;
                    state        <= ST_INTERVAL;
                end

                ST_INTERVAL: begin
                    if (int_cnt != INT_W'(INTERVAL_CYCLES - 1)) begin
                        int_cnt <= int_cnt + INT_W'(1);
                    end else if (start) begin
                        phase    <= PH_POLL;
                        poll_cnt <= '0;
                        state    <= ST_ISSUE;
                        i2c_en   <= 1'b1;
                        {i2c_read_write, i2c_register_address, i2c_data_out} <= xfer_fields(PH_POLL, 3'd0);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_HALT: begin
                    if (!start) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bme280_sequencer.sv
// Scoreboard bench for bme280_sequencer: a timed I2C master model answers each request,
// expected transactions and samples are queued by a register-level sensor model.
module tb_bme280_sequencer;

    localparam int XFER     = 8;
    localparam int INTERVAL = 20;
    localparam int MAXP     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        sample_valid;
    logic [19:0] temp_raw;
    logic [19:0] press_raw;
    logic [15:0] hum_raw;
    logic        error;
    logic        i2c_en;
    logic [6:0]  i2c_slave_address;
    logic        i2c_read_write;
    logic [7:0]  i2c_register_address;
    logic [7:0]  i2c_data_out;
    logic [7:0]  i2c_data_in;

    bme280_sequencer #(
        .SLAVE_ADDR      (7'h76),
        .XFER_CYCLES     (XFER),
        .INTERVAL_CYCLES (INTERVAL),
        .MAX_POLLS       (MAXP),
        .CTRL_HUM_VAL    (8'h01),
        .CTRL_MEAS_VAL   (8'h27),
        .CONFIG_VAL      (8'h00)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .busy                 (busy),
        .sample_valid         (sample_valid),
        .temp_raw             (temp_raw),
        .press_raw            (press_raw),
        .hum_raw              (hum_raw),
        .error                (error),
        .i2c_en               (i2c_en),
        .i2c_slave_address    (i2c_slave_address),
        .i2c_read_write       (i2c_read_write),
        .i2c_register_address (i2c_register_address),
        .i2c_data_out         (i2c_data_out),
        .i2c_data_in          (i2c_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
        int         gap;
    } txn_t;

    typedef struct {
        logic [19:0] p;
        logic [19:0] t;
        logic [15:0] h;
    } smp_t;

    txn_t       exp_txn[$];
    smp_t       exp_smp[$];
    logic [7:0] status_q[$];
    logic [7:0] data_bytes [8];

    int errors       = 0;
    int checks       = 0;
    int cyc          = 0;
    int samples_seen = 0;
    int last_en_cyc  = 0;
    int drv_cnt      = -1;
    logic [7:0] drv_val;
    logic [7:0] held_reg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_add(input logic rw, input logic [7:0] addr, input logic [7:0] data, input int gap);
        txn_t e;
        e.rw = rw; e.addr = addr; e.data = data; e.gap = gap;
        exp_txn.push_back(e);
    endtask

    // Three configuration writes; the first has no fixed distance to its predecessor
    task automatic push_cfg();
        exp_add(1'b0, 8'hF2, 8'h01, 0);
        exp_add(1'b0, 8'hF4, 8'h27, XFER);
        exp_add(1'b0, 8'hF5, 8'h00, XFER);
    endtask

    // One measurement cycle: n_busy "measuring" statuses, then reads of n_reads data bytes
    task automatic push_sample(input int n_busy, input int first_gap, input int n_reads);
        int   polls;
        smp_t s;
        polls = (n_busy < MAXP) ? n_busy + 1 : MAXP;
        for (int i = 0; i < polls; i++) begin
            exp_add(1'b1, 8'hF3, 8'h00, (i == 0) ? first_gap : XFER);
            if (i < n_busy) status_q.push_back(8'($urandom) | 8'h08);
            else            status_q.push_back(8'($urandom) & 8'hF7);
        end
        if (n_busy < MAXP) begin
            for (int b = 0; b < n_reads; b++) exp_add(1'b1, 8'hF7 + 8'(b), 8'h00, XFER);
            if (n_reads == 8) begin
                s.p = 20'(int'(data_bytes[0]) * 4096 + int'(data_bytes[1]) * 16 + int'(data_bytes[2]) / 16);
                s.t = 20'(int'(data_bytes[3]) * 4096 + int'(data_bytes[4]) * 16 + int'(data_bytes[5]) / 16);
                s.h = 16'(int'(data_bytes[6]) * 256 + int'(data_bytes[7]));
                exp_smp.push_back(s);
            end
        end
    endtask

    function automatic logic [7:0] respond(input logic [7:0] addr);
        logic [7:0] v;
        v = 8'h00;
        if (addr == 8'hF3) begin
            if (status_q.size() > 0) v = status_q.pop_front();
            else                     v = 8'h08;
        end else if (addr >= 8'hF7 && addr <= 8'hFE) begin
            v = data_bytes[addr - 8'hF7];
        end
        return v;
    endfunction

    // Master model: read data is valid only on the single clock edge XFER cycles after the request
    always @(negedge clk) begin
        if (!rst) begin
            drv_cnt = -1;
        end else if (drv_cnt > 0) begin
            check("en_in_wait", 32'(i2c_en), 32'd0);
            check("reg_held", 32'(i2c_register_address), 32'(held_reg));
            drv_cnt--;
            i2c_data_in = (drv_cnt == 0) ? drv_val : 8'($urandom);
        end else begin
            if (drv_cnt == 0) begin
                drv_cnt     = -1;
                i2c_data_in = 8'($urandom);
            end
            if (i2c_en) begin
                held_reg    = i2c_register_address;
                drv_val     = i2c_read_write ? respond(i2c_register_address) : 8'($urandom);
                drv_cnt     = XFER - 1;
                i2c_data_in = 8'($urandom);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a request or publishes a sample
    always @(negedge clk) begin : mon
        txn_t e;
        smp_t s;
        if (rst && i2c_en) begin
            if (exp_txn.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_txn: reg %0h rw %0b (cycle %0d)", i2c_register_address, i2c_read_write, cyc);
            end else begin
                e = exp_txn.pop_front();
                check("txn_rw", 32'(i2c_read_write), 32'(e.rw));
                check("txn_reg", 32'(i2c_register_address), 32'(e.addr));
                if (!e.rw) check("txn_wdata", 32'(i2c_data_out), 32'(e.data));
                if (e.gap != 0) check("txn_gap", 32'(cyc - last_en_cyc), 32'(e.gap));
            end
            last_en_cyc = cyc;
        end
        if (rst && sample_valid) begin
            if (exp_smp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: p %0h t %0h h %0h", press_raw, temp_raw, hum_raw);
            end else begin
                s = exp_smp.pop_front();
                check("press_raw", 32'(press_raw), 32'(s.p));
                check("temp_raw", 32'(temp_raw), 32'(s.t));
                check("hum_raw", 32'(hum_raw), 32'(s.h));
            end
            samples_seen++;
        end
    end

    task automatic wait_samples(input int target, input string name);
        int n;
        n = 0;
        while (samples_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(samples_seen), 32'(target));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 8; i++) data_bytes[i] = 8'($urandom);
    endtask

    initial begin
        int n;
        int found;
        int smp_base;
        rst         = 1'b0;
        start       = 1'b0;
        i2c_data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(i2c_en), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_press", 32'(press_raw), 32'd0);
        check("rst_temp", 32'(temp_raw), 32'd0);
        check("rst_hum", 32'(hum_raw), 32'd0);
        check("rst_rw", 32'(i2c_read_write), 32'd0);
        check("rst_regaddr", 32'(i2c_register_address), 32'd0);
        check("slave_addr", 32'(i2c_slave_address), 32'h76);
        rst = 1'b1;
        @(negedge clk);

        // Known sample, then one more without reconfiguration
        data_bytes = '{8'h51, 8'h23, 8'h40, 8'h7E, 8'h55, 8'h90, 8'h6A, 8'h12};
        push_cfg();
        push_sample(0, XFER, 8);
        start = 1'b1;
        @(negedge clk);
        check("busy_run", 32'(busy), 32'd1);
        wait_samples(1, "sample_dir");
        check("press_dir", 32'(press_raw), 32'h51234);
        check("temp_dir", 32'(temp_raw), 32'h7E559);
        check("hum_dir", 32'(hum_raw), 32'h6A12);
        randomize_data();
        push_sample(int'($urandom_range(0, 2)), XFER + 1 + INTERVAL, 8);
        wait_samples(2, "sample_cont");
        start = 1'b0;
        wait_idle("idle_after_interval");
        check("drain_a", 32'(exp_txn.size()), 32'd0);

        // Stop while byte 3 is in flight, then restart from configuration
        randomize_data();
        push_cfg();
        push_sample(0, XFER, 4);
        smp_base = samples_seen;
        start = 1'b1;
        found = 0;
        n = 0;
        while (found == 0 && n < 500) begin
            @(negedge clk);
            n++;
            if (i2c_en && i2c_register_address == 8'hFA) found = 1;
        end
        check("stop_point", 32'(found), 32'd1);
        start = 1'b0;
        wait_idle("idle_after_stop");
        repeat (INTERVAL) @(negedge clk);
        check("drain_stop", 32'(exp_txn.size()), 32'd0);
        check("no_partial_sample", 32'(samples_seen), 32'(smp_base));
        randomize_data();
        push_cfg();
        push_sample(1, XFER, 8);
        start = 1'b1;
        wait_samples(smp_base + 1, "sample_restart");
        start = 1'b0;
        wait_idle("idle_after_restart");

        // Sensor never finishes measuring
        push_cfg();
        push_sample(MAXP, XFER, 8);
        start = 1'b1;
        n = 0;
        while (!error && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("error_set", 32'(error), 32'd1);
        repeat (40) @(negedge clk);
        check("drain_halt", 32'(exp_txn.size()), 32'd0);
        check("halt_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_idle("idle_after_halt");
        check("error_sticky", 32'(error), 32'd1);

        // Reset in the middle of a transaction wait
        push_cfg();
        start = 1'b1;
        n = 0;
        while (!i2c_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("en_before_rst", 32'(i2c_en), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        exp_txn.delete();
        status_q.delete();
        @(negedge clk);
        check("wrst_en", 32'(i2c_en), 32'd0);
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_valid", 32'(sample_valid), 32'd0);
        check("wrst_error", 32'(error), 32'd0);
        check("wrst_raw", 32'(press_raw | temp_raw | 20'(hum_raw)), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Two busy polls then ready, followed by a run of random samples
        randomize_data();
        push_cfg();
        push_sample(2, XFER, 8);
        smp_base = samples_seen;
        start = 1'b1;
        wait_samples(smp_base + 1, "sample_late_ready");
        check("error_clear", 32'(error), 32'd0);
        for (int k = 0; k < 6; k++) begin
            randomize_data();
            push_sample(int'($urandom_range(0, 2)), XFER + 1 + INTERVAL, 8);
            wait_samples(smp_base + 2 + k, "sample_rand");
        end
        start = 1'b0;
        wait_idle("idle_final");
        check("drain_txn", 32'(exp_txn.size()), 32'd0);
        check("drain_smp", 32'(exp_smp.size()), 32'd0);
        check("error_final", 32'(error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
